// File: rtl/barrett_red.sv
// barrett_red: four-stage pipelined Barrett reducer, returns {in_H, in_L} mod Q with valid/ready.
// Optional BARRETT_RANGE_CHECK_EN builds an x >= Q*Q detector that drives the sticky err flag.
`ifndef DATAWIDTH
`define DATAWIDTH 14
`endif

module barrett_red #(
    parameter int W  = `DATAWIDTH,
    parameter int Q  = 12289,
    parameter int MU = 21843
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_H,
    input  logic [W-1:0] in_L,
    input  logic         in_tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_r,
    output logic         out_tag,
    output logic         err
);
    localparam logic [W+1:0]   Q_R  = (W+2)'(Q);
    localparam logic [W+1:0]   Q2_R = (W+2)'(2 * Q);
    localparam logic [4*W-1:0] MU_X = (4*W)'(MU);

    function automatic logic [W:0] quot_est(input logic [2*W-1:0] x);
        logic [4*W-1:0] p;
        p = {{(2*W){1'b0}}, x} * MU_X;
        return (W+1)'(p >> (2*W));
    endfunction

    // Only the low W+2 bits matter: the true remainder is below 3Q < 2^(W+2).
    function automatic logic [W+1:0] rem_est(input logic [2*W-1:0] x, input logic [W:0] t);
        logic [2*W+1:0] tq;
        tq = {{(W+1){1'b0}}, t} * (2*W+2)'(Q);
        return (W+2)'(x) - (W+2)'(tq);
    endfunction

    function automatic logic [W-1:0] final_sub(input logic [W+1:0] r);
        logic [W+1:0] s;
        if (r >= Q2_R)
            s = r - Q2_R;
        else if (r >= Q_R)
            s = r - Q_R;
        else
            s = r;
        return W'(s);
    endfunction

    logic           en;
    logic           vld_p1, vld_p2, vld_p3;
    logic [2*W-1:0] x_p1, x_p2;
    logic           tag_p1, tag_p2, tag_p3;
    logic [W:0]     t_p2;
    logic [W+1:0]   r_p3;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            vld_p3    <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= 1'b0;
        end else if (en) begin
            vld_p1    <= in_valid;
            vld_p2    <= vld_p1;
            vld_p3    <= vld_p2;
            out_valid <= vld_p3;
            // S4: conditional subtraction into [0, Q)
            out_r     <= final_sub(r_p3);
            out_tag   <= tag_p3;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            // S1: capture product
            x_p1   <= {in_H, in_L};
            tag_p1 <= in_tag;
            // S2: quotient estimate
            t_p2   <= quot_est(x_p1);
            x_p2   <= x_p1;
            tag_p2 <= tag_p1;
            // S3: partial remainder
            r_p3   <= rem_est(x_p2, t_p2);
            tag_p3 <= tag_p2;
        end
    end

`ifdef BARRETT_RANGE_CHECK_EN
    localparam logic [2*W-1:0] QQ = (2*W)'(longint'(Q) * longint'(Q));

    logic bad_p1, bad_p2, bad_p3, bad_p4;
    logic err_q;

    always_ff @(posedge clk) begin
        if (en) begin
            bad_p1 <= {in_H, in_L} >= QQ;
            bad_p2 <= bad_p1;
            bad_p3 <= bad_p2;
            bad_p4 <= bad_p3;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            err_q <= 1'b0;
        else if (out_valid && out_ready && bad_p4)
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
